// File: rtl/oc8051_cxrom_arbiter_if.sv
// Bundle of fetch, MOVC and cxrom port signals around the code-ROM arbiter.
// master: arbiter side; slave: requesters plus ROM side.
interface oc8051_cxrom_arbiter_if;
    logic        fet_req;
    logic [15:0] fet_addr;
    logic        fet_ack;
    logic [31:0] fet_data;
    logic        mov_req;
    logic [15:0] mov_addr;
    logic        mov_ack;
    logic [31:0] mov_data;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic        rom_ready;
    logic [31:0] rom_data;
    logic        busy;
    logic        err;

    modport master (
        input  fet_req, fet_addr, mov_req, mov_addr,
        input  rom_ready, rom_data,
        output fet_ack, fet_data, mov_ack, mov_data,
        output rom_rd, rom_addr, busy, err
    );

    modport slave (
        output fet_req, fet_addr, mov_req, mov_addr,
        output rom_ready, rom_data,
        input  fet_ack, fet_data, mov_ack, mov_data,
        input  rom_rd, rom_addr, busy, err
    );
endinterface

// File: rtl/oc8051_cxrom_arbiter.sv
// Code-ROM port arbiter: fetch vs MOVC, starvation guard, ROM watchdog.
// Optional last-word buffer enabled by OC8051_CXROM_ARB_BUFFER_EN.
module oc8051_cxrom_arbiter #(
    parameter int unsigned MAX_MOVC_RUN = 4,
    parameter int unsigned TIMEOUT      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    oc8051_cxrom_arbiter_if.master        bus
);
    localparam logic [3:0] RUN_MAX = 4'(MAX_MOVC_RUN);
    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        own_mov_q, own_mov_d;
    logic        abort_q, abort_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [31:0] fet_data_q, fet_data_d;
    logic [31:0] mov_data_q, mov_data_d;

    logic        req_any;
    logic        grant_mov;
    logic [15:0] gnt_addr;
    logic        hit;
    logic [31:0] hit_data;

`ifdef OC8051_CXROM_ARB_BUFFER_EN
    logic        buf_vld_q, buf_vld_d;
    logic [15:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;

    assign hit      = buf_vld_q && (buf_addr_q == gnt_addr);
    assign hit_data = buf_data_q;
`else
    assign hit      = 1'b0;
    assign hit_data = 32'h0;
`endif

    // MOVC wins unless fetch has been passed over MAX_MOVC_RUN times
    assign req_any   = bus.fet_req | bus.mov_req;
    assign grant_mov = bus.mov_req &&
                       !(bus.fet_req && run_cnt_q == RUN_MAX);
    assign gnt_addr  = grant_mov ? bus.mov_addr : bus.fet_addr;

    always_comb begin
        state_d    = state_q;
        own_mov_d  = own_mov_q;
        abort_d    = abort_q;
        run_cnt_d  = run_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        rom_addr_d = rom_addr_q;
        fet_data_d = fet_data_q;
        mov_data_d = mov_data_q;
`ifdef OC8051_CXROM_ARB_BUFFER_EN
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!bus.fet_req) run_cnt_d = 4'd0;
                if (req_any) begin
                    own_mov_d  = grant_mov;
                    abort_d    = 1'b0;
                    rom_addr_d = gnt_addr;
                    if (!grant_mov)
                        run_cnt_d = 4'd0;
                    else if (bus.fet_req)
                        run_cnt_d = run_cnt_q + 4'd1;
                    if (hit) begin
                        if (grant_mov) mov_data_d = hit_data;
                        else           fet_data_d = hit_data;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = 8'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rom_ready) begin
                    if (own_mov_q) mov_data_d = bus.rom_data;
                    else           fet_data_d = bus.rom_data;
`ifdef OC8051_CXROM_ARB_BUFFER_EN
                    buf_vld_d  = 1'b1;
                    buf_addr_d = rom_addr_q;
                    buf_data_d = bus.rom_data;
`endif
                    state_d = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_cnt_d == TMO_MAX) begin
                        if (own_mov_q) mov_data_d = 32'h0;
                        else           fet_data_d = 32'h0;
                        abort_d = 1'b1;
`ifdef OC8051_CXROM_ARB_BUFFER_EN
                        buf_vld_d = 1'b0;
`endif
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            own_mov_q  <= 1'b0;
            abort_q    <= 1'b0;
            run_cnt_q  <= 4'd0;
            tmo_cnt_q  <= 8'd0;
            rom_addr_q <= 16'h0;
            fet_data_q <= 32'h0;
            mov_data_q <= 32'h0;
`ifdef OC8051_CXROM_ARB_BUFFER_EN
            buf_vld_q  <= 1'b0;
            buf_addr_q <= 16'h0;
            buf_data_q <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            own_mov_q  <= own_mov_d;
            abort_q    <= abort_d;
            run_cnt_q  <= run_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rom_addr_q <= rom_addr_d;
            fet_data_q <= fet_data_d;
            mov_data_q <= mov_data_d;
`ifdef OC8051_CXROM_ARB_BUFFER_EN
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
`endif
        end
    end

    assign bus.rom_rd   = (state_q == S_ISSUE);
    assign bus.rom_addr = rom_addr_q;
    assign bus.fet_ack  = (state_q == S_RESP) && !own_mov_q;
    assign bus.mov_ack  = (state_q == S_RESP) && own_mov_q;
    assign bus.err      = (state_q == S_RESP) && abort_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.fet_data = fet_data_q;
    assign bus.mov_data = mov_data_q;
endmodule

// File: tb/tb_oc8051_cxrom_arbiter.sv
// Directed bench for oc8051_cxrom_arbiter with a small cxrom responder.
module tb_oc8051_cxrom_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oc8051_cxrom_arbiter_if bus();

    oc8051_cxrom_arbiter #(
        .MAX_MOVC_RUN(4),
        .TIMEOUT(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int cnt = 0;
    bit pend = 0;
    bit frc_rdy = 0;
    bit outst = 0;
    int rd_n = 0;
    int fack_n = 0;
    int mack_n = 0;
    int err_n = 0;
    int ovl_n = 0;

    function automatic logic [31:0] word(input logic [15:0] a);
        if (a == 16'h0010) return 32'hA1B2C3D4;
        return {~a, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock; the ROM answers lat cycles after each rom_rd
    task automatic tick;
        @(posedge clk);
        #1;
        bus.rom_ready = 1'b0;
        if (rst) begin
            pend  = 0;
            outst = 0;
        end else if (bus.rom_rd) begin
            rd_n++;
            if (outst) ovl_n++;
            outst = 1;
            pend  = 1;
            cnt   = lat;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend = 0;
                bus.rom_ready = 1'b1;
                bus.rom_data  = word(bus.rom_addr);
            end
        end
        if (frc_rdy) begin
            bus.rom_ready = 1'b1;
            bus.rom_data  = 32'hDEADBEEF;
        end
        if (bus.fet_ack) fack_n++;
        if (bus.mov_ack) mack_n++;
        if (bus.err) err_n++;
        if (bus.fet_ack || bus.mov_ack) outst = 0;
    endtask

    task automatic run_until_ack(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.fet_ack || bus.mov_ack) && n < max);
        chk("ack_seen", 32'(bus.fet_ack | bus.mov_ack), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int a0;
        logic [9:0] ord;
        rst = 1'b1;
        bus.fet_req = 1'b0;
        bus.fet_addr = 16'h0;
        bus.mov_req = 1'b0;
        bus.mov_addr = 16'h0;
        bus.rom_ready = 1'b0;
        bus.rom_data = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ctl", 32'({bus.busy, bus.rom_rd, bus.fet_ack,
                            bus.mov_ack, bus.err}), 32'd0);
        chk("rst_fdat", bus.fet_data, 32'h0);
        chk("rst_mdat", bus.mov_data, 32'h0);
        chk("rst_addr", 32'(bus.rom_addr), 32'h0);
        tick();

        // basic fetch, ROM answers 2 cycles after rom_rd
        lat = 2;
        r0 = rd_n;
        bus.fet_addr = 16'h0010;
        bus.fet_req = 1'b1;
        tick();
        chk("t1_rd", 32'(bus.rom_rd), 32'd1);
        chk("t1_addr", 32'(bus.rom_addr), 32'h0010);
        run_until_ack(20, n);
        chk("t1_lat", n + 1, 32'd4);
        chk("t1_fack", 32'(bus.fet_ack), 32'd1);
        chk("t1_data", bus.fet_data, 32'hA1B2C3D4);
        chk("t1_err", 32'(bus.err), 32'd0);
        bus.fet_req = 1'b0;
        tick();
        chk("t1_idle", 32'({bus.busy, bus.fet_ack}), 32'd0);
        chk("t1_rdn", rd_n - r0, 32'd1);
        chk("t1_mdat", bus.mov_data, 32'h0);

        // both held: MOVC x4, fetch, MOVC x4, fetch
        lat = 1;
        bus.fet_addr = 16'h0100;
        bus.mov_addr = 16'h0200;
        bus.fet_req = 1'b1;
        bus.mov_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_until_ack(20, n);
            ord[i] = bus.mov_ack;
        end
        bus.fet_req = 1'b0;
        bus.mov_req = 1'b0;
        tick();
        chk("t2_order", 32'(ord), 32'h1EF);
        chk("t2_ovl", ovl_n, 32'd0);
        chk("t2_fdat", bus.fet_data, word(16'h0100));
        chk("t2_mdat", bus.mov_data, word(16'h0200));

        // ROM never answers: 32 WAIT cycles then abort
        lat = 1000;
        a0 = err_n;
        bus.fet_addr = 16'h0300;
        bus.fet_req = 1'b1;
        run_until_ack(60, n);
        chk("t3_lat", n, 32'd34);
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_fack", 32'(bus.fet_ack), 32'd1);
        chk("t3_data", bus.fet_data, 32'h0);
        bus.fet_req = 1'b0;
        pend = 0;
        frc_rdy = 1;
        tick();
        tick();
        frc_rdy = 0;
        chk("t3_late", 32'({bus.busy, bus.fet_ack, bus.err}), 32'd0);
        chk("t3_hold", bus.fet_data, 32'h0);
        chk("t3_errn", err_n - a0, 32'd1);
        chk("t3_mdat", bus.mov_data, word(16'h0200));

        // reset the cycle after rom_rd
        lat = 2;
        bus.fet_addr = 16'h0400;
        bus.fet_req = 1'b1;
        tick();
        chk("t4_rd", 32'(bus.rom_rd), 32'd1);
        rst = 1'b1;
        bus.fet_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("t4_ctl", 32'({bus.busy, bus.rom_rd, bus.fet_ack,
                           bus.mov_ack, bus.err}), 32'd0);
        chk("t4_fdat", bus.fet_data, 32'h0);
        chk("t4_mdat", bus.mov_data, 32'h0);
        chk("t4_addr", 32'(bus.rom_addr), 32'h0);
        a0 = fack_n + mack_n;
        repeat (4) tick();
        chk("t4_noack", fack_n + mack_n - a0, 32'd0);
        lat = 1;
        bus.fet_addr = 16'h0410;
        bus.fet_req = 1'b1;
        run_until_ack(20, n);
        chk("t4_lat", n, 32'd3);
        chk("t4_data", bus.fet_data, word(16'h0410));
        bus.fet_req = 1'b0;
        tick();

        // MOVC dropped in WAIT, pending fetch served next
        lat = 3;
        a0 = mack_n;
        bus.mov_addr = 16'h0500;
        bus.fet_addr = 16'h0510;
        bus.mov_req = 1'b1;
        bus.fet_req = 1'b1;
        tick();
        chk("t5_addr", 32'(bus.rom_addr), 32'h0500);
        tick();
        bus.mov_req = 1'b0;
        run_until_ack(20, n);
        chk("t5_mack", 32'(bus.mov_ack), 32'd1);
        chk("t5_mdat", bus.mov_data, word(16'h0500));
        run_until_ack(20, n);
        chk("t5_fack", 32'(bus.fet_ack), 32'd1);
        chk("t5_fdat", bus.fet_data, word(16'h0510));
        bus.fet_req = 1'b0;
        tick();
        chk("t5_mackn", mack_n - a0, 32'd1);

        // same fetch address twice
        lat = 1;
        bus.fet_addr = 16'h0020;
        bus.fet_req = 1'b1;
        run_until_ack(20, n);
        chk("t6_lat1", n, 32'd3);
        bus.fet_req = 1'b0;
        tick();
        r0 = rd_n;
        bus.fet_req = 1'b1;
        run_until_ack(20, n);
`ifdef OC8051_CXROM_ARB_BUFFER_EN
        chk("t6_lat2", n, 32'd1);
        chk("t6_rdn", rd_n - r0, 32'd0);
`else
        chk("t6_lat2", n, 32'd3);
        chk("t6_rdn", rd_n - r0, 32'd1);
`endif
        chk("t6_data", bus.fet_data, word(16'h0020));
        bus.fet_req = 1'b0;
        tick();
        chk("t6_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
